// File: rtl/key_event_queue.sv
// key_event_queue: synchronizes and debounces the 3-bit key code, then queues key-press events.
// Optional auto-repeat for left/right/down is compiled in when KEY_AUTOREPEAT_EN is defined.
module key_event_queue #(
  parameter int unsigned DEPTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 16
`ifdef KEY_AUTOREPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY    = 5000,
  parameter int unsigned REPEAT_PERIOD   = 1000
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [2:0]               key_in,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     evt_valid,
  output logic [2:0]               evt_code,
  output logic [$clog2(DEPTH):0]   evt_count,
  output logic                     overflow
);

  localparam int unsigned CW  = 3;
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned PW  = AW + 1;
  localparam int unsigned SW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HIT = (DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0;
  localparam logic [CW-1:0] KEY_NONE = CW'(0);
  localparam logic [CW-1:0] KEY_ESC  = CW'(1);

  logic [CW-1:0] sync1, code_s, code_prev, last_acc;
  logic [SW-1:0] stab_cnt;
  logic          changed_c, hit_c, accept_c, esc_c, press_c, push_c;

  logic [CW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt, count_nxt;
  logic          full_c, empty_c, we_c, ovf_nxt;
  logic [CW-1:0] head_nxt;

  // Synchronizer and stability counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= '0;
      code_s    <= '0;
      code_prev <= '0;
      stab_cnt  <= '0;
      last_acc  <= '0;
    end else begin
      sync1     <= key_in;
      code_s    <= sync1;
      code_prev <= code_s;
      if (changed_c)
        stab_cnt <= '0;
      else if (stab_cnt != SW'(DEBOUNCE_CYCLES))
        stab_cnt <= stab_cnt + SW'(1);
      if (accept_c)
        last_acc <= code_s;
    end
  end

  // Acceptance fires once, on the edge the counter reaches DEBOUNCE_CYCLES-1
  always_comb begin
    changed_c = (code_s != code_prev);
    if (DEBOUNCE_CYCLES == 1)
      hit_c = changed_c;
    else
      hit_c = !changed_c && (stab_cnt == SW'(HIT));
    accept_c = hit_c && (code_s != last_acc);
    esc_c    = accept_c && (code_s == KEY_ESC);
    press_c  = accept_c && (code_s != KEY_NONE) && (code_s != KEY_ESC);
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rep_cnt;
  logic          rep_first, rep_run_c, rep_fire_c;

  always_comb begin
    rep_run_c  = !changed_c && (code_s == last_acc) && (last_acc inside {3'd5, 3'd6, 3'd7});
    rep_fire_c = rep_run_c &&
                 (rep_cnt == (rep_first ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1)));
  end

  // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (flush || accept_c || !rep_run_c) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (rep_fire_c) begin
      rep_cnt   <= '0;
      rep_first <= 1'b0;
    end else begin
      rep_cnt   <= rep_cnt + RW'(1);
    end
  end

  assign push_c = press_c || rep_fire_c;
`else
  assign push_c = press_c;
`endif

  // Pointer update: flush > escape > push/pop
  always_comb begin
    wr_nxt  = wr_ptr;
    rd_nxt  = rd_ptr;
    ovf_nxt = overflow;
    we_c    = 1'b0;
    empty_c = (wr_ptr == rd_ptr);
    full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    if (flush) begin
      rd_nxt  = wr_ptr;
      ovf_nxt = 1'b0;
    end else if (esc_c) begin
      we_c   = 1'b1;
      rd_nxt = wr_ptr;
      wr_nxt = wr_ptr + PW'(1);
    end else begin
      if (pop && !empty_c)
        rd_nxt = rd_ptr + PW'(1);
      if (push_c) begin
        if (!full_c || pop) begin
          we_c   = 1'b1;
          wr_nxt = wr_ptr + PW'(1);
        end else begin
          ovf_nxt = 1'b1;
        end
      end
    end
    count_nxt = wr_nxt - rd_nxt;
    if (count_nxt == '0)
      head_nxt = KEY_NONE;
    else if (we_c && (wr_ptr[AW-1:0] == rd_nxt[AW-1:0]))
      head_nxt = code_s;
    else
      head_nxt = mem[rd_nxt[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (we_c)
      mem[wr_ptr[AW-1:0]] <= code_s;
  end

  // Outputs are registered from the next-state view so they track the pointers exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      evt_valid <= 1'b0;
      evt_code  <= '0;
      evt_count <= '0;
    end else begin
      wr_ptr    <= wr_nxt;
      rd_ptr    <= rd_nxt;
      overflow  <= ovf_nxt;
      evt_valid <= (count_nxt != '0);
      evt_code  <= head_nxt;
      evt_count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_key_event_queue.sv
// tb_key_event_queue: directed tables, hand sequences and random stimulus against a queue-based model.
// Build with KEY_AUTOREPEAT_EN defined to exercise auto-repeat.
module tb_key_event_queue;

  localparam int DEPTH = 4;
  localparam int DEB   = 4;
`ifdef KEY_AUTOREPEAT_EN
  localparam int RD    = 20;
  localparam int RP    = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] key_in;
  logic       pop, flush;
  logic       evt_valid;
  logic [2:0] evt_code;
  logic [2:0] evt_count;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  key_event_queue #(
    .DEPTH(DEPTH),
    .DEBOUNCE_CYCLES(DEB)
`ifdef KEY_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .pop(pop), .flush(flush),
    .evt_valid(evt_valid), .evt_code(evt_code), .evt_count(evt_count), .overflow(overflow)
  );

  // Reference model: key_in delayed two samples, run length of identical samples, event queue
  logic [2:0] m_s1, m_cs, m_prev, m_last;
  int         m_run, m_hold;
  logic [2:0] m_q[$];
  bit         m_ovf;

  always @(posedge clk or negedge rst_n) begin
    logic [2:0] cs;
    bit acc, push, esc, popped;
    if (!rst_n) begin
      m_s1 = 0; m_cs = 0; m_prev = 0; m_last = 0;
      m_run = 1; m_hold = 0; m_q.delete(); m_ovf = 0;
    end else begin
      cs = m_cs; m_cs = m_s1; m_s1 = key_in;
      if (cs == m_prev) begin
        if (m_run < 100000) m_run++;
      end else m_run = 1;
      m_prev = cs;
      acc  = (m_run == DEB) && (cs != m_last);
      push = acc && (cs > 3'd1);
      esc  = acc && (cs == 3'd1);
`ifdef KEY_AUTOREPEAT_EN
      if (flush || acc || m_run == 1 || cs != m_last || !(m_last inside {3'd5, 3'd6, 3'd7}))
        m_hold = 0;
      else begin
        m_hold++;
        if (m_hold == RD || (m_hold > RD && (m_hold - RD) % RP == 0)) push = 1;
      end
`endif
      if (acc) m_last = cs;
      if (flush) begin
        m_q.delete(); m_ovf = 0;
      end else if (esc) begin
        m_q.delete(); m_q.push_back(3'd1);
      end else begin
        popped = pop && (m_q.size() > 0);
        if (popped) void'(m_q.pop_front());
        if (push) begin
          if (m_q.size() < DEPTH) m_q.push_back(cs);
          else m_ovf = 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic cmp_model();
    int ec, en;
    en = m_q.size();
    ec = (en != 0) ? int'(m_q[0]) : 0;
    n_tests++;
    if (evt_valid !== (en != 0) || int'(evt_code) != ec || int'(evt_count) != en || overflow !== m_ovf) begin
      n_fail++;
      $display("FAIL model at %0t: got v=%0b code=%0d cnt=%0d ovf=%0b, expected v=%0b code=%0d cnt=%0d ovf=%0b",
               $time, evt_valid, evt_code, evt_count, overflow, en != 0, ec, en, m_ovf);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    cmp_model();
  endtask

  task automatic chk_out(input string nm, input int cnt, input int code, input int ovf);
    chk({nm, ".count"}, int'(evt_count), cnt);
    chk({nm, ".code"}, int'(evt_code), code);
    chk({nm, ".valid"}, int'(evt_valid), int'(cnt != 0));
    chk({nm, ".ovf"}, int'(overflow), ovf);
  endtask

  typedef struct {
    logic [2:0] key;
    bit         pop;
    bit         flush;
    int         cycles;
    int         exp_cnt;
    int         exp_code;
    int         exp_ovf;
  } vec_t;

  task automatic apply(input vec_t v, input string nm);
    key_in = v.key; pop = v.pop; flush = v.flush;
    repeat (v.cycles) tick();
    pop = 0; flush = 0;
    chk_out(nm, v.exp_cnt, v.exp_code, v.exp_ovf);
  endtask

  initial begin
    vec_t tab_a[$];
    vec_t tab_b[$];
    int   n, len;

    rst_n = 0; key_in = 0; pop = 0; flush = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_out("reset", 0, 0, 0);
    rst_n = 1;
    repeat (4) tick();

    // Latency: event visible after the sixth edge with DEBOUNCE_CYCLES=4
    key_in = 3'd5;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (t == 5) chk("latency.early", int'(evt_valid), 0);
      if (t == 6) chk_out("latency", 1, 5, 0);
    end
    key_in = 0;
    repeat (10) tick();
    chk_out("release", 1, 5, 0);
    pop = 1; tick(); pop = 0;
    chk_out("pop1", 0, 0, 0);

    // Bounce never stays stable long enough
    for (int i = 0; i < 10; i++) begin
      key_in = (i % 2 == 0) ? 3'd6 : 3'd0;
      repeat (2) tick();
    end
    key_in = 0;
    repeat (8) tick();
    chk_out("bounce", 0, 0, 0);

    // Fill to full, then overflow
    tab_a.push_back('{3'd3, 0, 0, 8, 1, 3, 0});
    tab_a.push_back('{3'd0, 0, 0, 8, 1, 3, 0});
    tab_a.push_back('{3'd4, 0, 0, 8, 2, 3, 0});
    tab_a.push_back('{3'd0, 0, 0, 8, 2, 3, 0});
    tab_a.push_back('{3'd5, 0, 0, 8, 3, 3, 0});
    tab_a.push_back('{3'd0, 0, 0, 8, 3, 3, 0});
    tab_a.push_back('{3'd6, 0, 0, 8, 4, 3, 0});
    tab_a.push_back('{3'd0, 0, 0, 8, 4, 3, 0});
    tab_a.push_back('{3'd7, 0, 0, 8, 4, 3, 1});
    foreach (tab_a[i]) apply(tab_a[i], $sformatf("tabA[%0d]", i));

    // Push and pop on the same edge while full
    key_in = 3'd2;
    repeat (5) tick();
    pop = 1; tick(); pop = 0;
    chk_out("full_pushpop", 4, 4, 1);

    // Escape, flush, held key across flush, pop empty, refill
    tab_b.push_back('{3'd0, 0, 0, 8, 4, 4, 1});
    tab_b.push_back('{3'd0, 0, 1, 1, 0, 0, 0});
    tab_b.push_back('{3'd5, 0, 0, 8, 1, 5, 0});
    tab_b.push_back('{3'd0, 0, 0, 8, 1, 5, 0});
    tab_b.push_back('{3'd6, 0, 0, 8, 2, 5, 0});
    tab_b.push_back('{3'd0, 0, 0, 8, 2, 5, 0});
    tab_b.push_back('{3'd1, 0, 0, 8, 1, 1, 0});
    tab_b.push_back('{3'd0, 0, 0, 8, 1, 1, 0});
    tab_b.push_back('{3'd0, 0, 1, 1, 0, 0, 0});
    tab_b.push_back('{3'd5, 0, 0, 8, 1, 5, 0});
    tab_b.push_back('{3'd5, 0, 1, 1, 0, 0, 0});
    tab_b.push_back('{3'd5, 0, 0, 10, 0, 0, 0});
    tab_b.push_back('{3'd0, 0, 0, 8, 0, 0, 0});
    tab_b.push_back('{3'd0, 1, 0, 3, 0, 0, 0});
    tab_b.push_back('{3'd3, 0, 0, 8, 1, 3, 0});
    tab_b.push_back('{3'd0, 0, 0, 8, 1, 3, 0});
    tab_b.push_back('{3'd4, 0, 0, 8, 2, 3, 0});
    tab_b.push_back('{3'd0, 0, 0, 8, 2, 3, 0});
    tab_b.push_back('{3'd6, 0, 0, 8, 3, 3, 0});
    foreach (tab_b[i]) apply(tab_b[i], $sformatf("tabB[%0d]", i));

    // Asynchronous reset with a key held across it
    key_in = 3'd7; rst_n = 0;
    #1;
    chk_out("async_rst", 0, 0, 0);
    cmp_model();
    repeat (2) tick();
    rst_n = 1;
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (t == 5) chk("held_rst.early", int'(evt_count), 0);
    end
    chk_out("held_rst", 1, 7, 0);
    key_in = 0;
    repeat (8) tick();
    flush = 1; tick(); flush = 0;

    // Long hold of 5: one event, plus repeats when enabled
    key_in = 3'd5;
    for (int t = 1; t <= 60; t++) begin
      tick();
      n = (t >= 6) ? 1 : 0;
`ifdef KEY_AUTOREPEAT_EN
      if (t >= 6 + RD) n += (t - 6 - RD) / RP + 1;
`endif
      chk($sformatf("hold5.t%0d.count", t), int'(evt_count), (n > DEPTH) ? DEPTH : n);
      chk($sformatf("hold5.t%0d.ovf", t), int'(overflow), int'(n > DEPTH));
    end
    key_in = 0;
    repeat (8) tick();
    flush = 1; tick(); flush = 0;
    key_in = 3'd3;
    repeat (60) tick();
    chk_out("hold3", 1, 3, 0);
    key_in = 0;
    repeat (8) tick();

    // Random segments against the model
    for (int seg = 0; seg < 150; seg++) begin
      key_in = 3'($urandom_range(0, 7));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 45)) : int'($urandom_range(1, 8));
      for (int c = 0; c < len; c++) begin
        pop   = ($urandom_range(0, 3) == 0);
        flush = ($urandom_range(0, 59) == 0);
        tick();
      end
    end
    pop = 0; flush = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
